instr_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute control FSM for the 19-bit CPU.

---
 rtl/instr_sequencer_pkg.sv | 58 +++++
 rtl/instr_sequencer_decoder.sv | 26 ++
 rtl/instr_sequencer.sv | 165 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared types and constants for the instruction sequencer
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    LOAD_NONE = 2'd0,
    LOAD_PC   = 2'd1,
    LOAD_IR   = 2'd2,
    LOAD_RF   = 2'd3
  } load_select_t;

  typedef enum logic [4:0] {
    OP_ADD  = 5'h00,
    OP_SUB  = 5'h01,
    OP_AND  = 5'h02,
    OP_OR   = 5'h03,
    OP_XOR  = 5'h04,
    OP_NOT  = 5'h05,
    OP_SHL  = 5'h06,
    OP_SHR  = 5'h07,
    OP_LD   = 5'h08,
    OP_ST   = 5'h09,
    OP_BR   = 5'h0A,
    OP_JMP  = 5'h0B,
    OP_HALT = 5'h0C
  } opcode_t;

  typedef enum logic [2:0] {
    CL_ALU  = 3'd0,
    CL_LD   = 3'd1,
    CL_ST   = 3'd2,
    CL_BR   = 3'd3,
    CL_JMP  = 3'd4,
    CL_HALT = 3'd5,
    CL_ILL  = 3'd6
  } instr_class_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_BUS     = 2'd2
  } err_code_t;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_INC    = 4'd2,
    S_DECODE = 4'd3,
    S_EXEC   = 4'd4,
    S_MEM    = 4'd5,
    S_WB     = 4'd6,
    S_BRANCH = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

endpackage

// File: rtl/instr_sequencer_decoder.sv
// rtl/instr_sequencer_decoder.sv - combinational opcode to instruction class decode
module instr_class_decoder
  import instr_sequencer_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output instr_class_t        cls
);

  always_comb begin
    cls = CL_ILL;
    case (opcode)
      OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB), OPCODE_W'(OP_AND), OPCODE_W'(OP_OR),
      OPCODE_W'(OP_XOR), OPCODE_W'(OP_NOT), OPCODE_W'(OP_SHL), OPCODE_W'(OP_SHR):
                         cls = CL_ALU;
      OPCODE_W'(OP_LD):   cls = CL_LD;
      OPCODE_W'(OP_ST):   cls = CL_ST;
      OPCODE_W'(OP_BR):   cls = CL_BR;
      OPCODE_W'(OP_JMP):  cls = CL_JMP;
      OPCODE_W'(OP_HALT): cls = CL_HALT;
      default:            cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute control FSM with bus watchdog and retire counter
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int INSTR_W  = 19,
  parameter int OPCODE_W = 5,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 32
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               FLAG_Z,
  input  logic               MEM_ACK,
  output logic               MEM_REQ,
  output logic               MEM_WE,
  output logic               ADDR_SEL,
  output logic               LOAD_REG,
  output load_select_t       LOAD_SELECT,
  output logic               INC_PC,
  output logic               IR_LOAD,
  output logic               ALU_EN,
  output logic               HALTED,
  output err_code_t          ERR_CODE,
  output logic [CNT_W-1:0]   RETIRED
);

  localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int TO_M1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_t           state, state_next;
  instr_class_t     cls, cls_q;
  err_code_t        err_q, err_set;
  logic [WD_W-1:0]  wd_cnt, wd_next;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             wd_hit;
  logic             unused_operand_bits;

  instr_class_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
    .opcode (INSTR[INSTR_W-1 -: OPCODE_W]),
    .cls    (cls)
  );

  assign unused_operand_bits = ^INSTR[INSTR_W-OPCODE_W-1:0];

  // Last permitted waiting cycle; an ACK in that same cycle still completes normally.
  assign wd_hit = (TIMEOUT != 0) && (wd_cnt == WD_W'(TO_M1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_RESET;
      cls_q     <= CL_ALU;
      err_q     <= ERR_NONE;
      wd_cnt    <= '0;
      retired_q <= '0;
    end else begin
      state  <= state_next;
      wd_cnt <= wd_next;
      if (state == S_DECODE) cls_q <= cls;
      if (err_set != ERR_NONE) err_q <= err_set;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    err_set     = ERR_NONE;
    retire      = 1'b0;
    MEM_REQ     = 1'b0;
    MEM_WE      = 1'b0;
    ADDR_SEL    = ADDR_PC;
    LOAD_REG    = 1'b0;
    LOAD_SELECT = LOAD_NONE;
    INC_PC      = 1'b0;
    ALU_EN      = 1'b0;
    HALTED      = 1'b0;
    case (state)
      S_RESET: begin
        LOAD_SELECT = LOAD_PC;
        state_next  = S_FETCH;
      end
      S_FETCH: begin
        MEM_REQ  = 1'b1;
        ADDR_SEL = ADDR_PC;
        if (MEM_ACK) begin
          state_next = S_INC;
        end else if (wd_hit) begin
          state_next = S_HALT;
          err_set    = ERR_BUS;
        end
      end
      S_INC: begin
        LOAD_SELECT = LOAD_PC;
        INC_PC      = 1'b1;
        state_next  = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          CL_ALU:         state_next = S_EXEC;
          CL_LD, CL_ST:   state_next = S_MEM;
          CL_BR, CL_JMP:  state_next = S_BRANCH;
          CL_HALT:        state_next = S_HALT;
          default: begin
            state_next = S_HALT;
            err_set    = ERR_ILLEGAL;
          end
        endcase
      end
      S_EXEC: begin
        ALU_EN     = 1'b1;
        state_next = S_WB;
      end
      S_MEM: begin
        MEM_REQ  = 1'b1;
        ADDR_SEL = ADDR_ALU;
        MEM_WE   = (cls_q == CL_ST);
        if (MEM_ACK) begin
          // Stores complete here; loads still need the register-file write.
          if (cls_q == CL_ST) begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end else begin
            state_next = S_WB;
          end
        end else if (wd_hit) begin
          state_next = S_HALT;
          err_set    = ERR_BUS;
        end
      end
      S_WB: begin
        LOAD_SELECT = LOAD_RF;
        LOAD_REG    = 1'b1;
        state_next  = S_FETCH;
        retire      = 1'b1;
      end
      S_BRANCH: begin
        if (cls_q == CL_JMP || FLAG_Z) begin
          LOAD_SELECT = LOAD_PC;
          LOAD_REG    = 1'b1;
        end
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT: begin
        HALTED = 1'b1;
      end
      default: state_next = S_RESET;
    endcase
  end

  always_comb begin
    wd_next = wd_cnt;
    if (state_next != state) begin
      wd_next = '0;
    end else if ((TIMEOUT != 0) && !MEM_ACK && (state == S_FETCH || state == S_MEM)) begin
      wd_next = wd_cnt + 1'b1;
    end
  end

  assign IR_LOAD  = (state == S_FETCH) && MEM_ACK;
  assign ERR_CODE = err_q;
  assign RETIRED  = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized self-checking bench for instr_sequencer
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int TO = 4;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic [18:0]  INSTR = '0;
  logic         FLAG_Z = 1'b0;
  logic         MEM_ACK = 1'b0;
  logic         MEM_REQ, MEM_WE, ADDR_SEL, LOAD_REG, INC_PC, IR_LOAD, ALU_EN, HALTED;
  load_select_t LOAD_SELECT;
  err_code_t    ERR_CODE;
  logic [31:0]  RETIRED;

  int n_checks = 0;
  int n_pass   = 0;
  int model_ret = 0;
  bit model_halted = 0;

  instr_sequencer #(.INSTR_W(19), .OPCODE_W(5), .TIMEOUT(TO), .CNT_W(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .INSTR(INSTR), .FLAG_Z(FLAG_Z), .MEM_ACK(MEM_ACK),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .ADDR_SEL(ADDR_SEL), .LOAD_REG(LOAD_REG),
    .LOAD_SELECT(LOAD_SELECT), .INC_PC(INC_PC), .IR_LOAD(IR_LOAD), .ALU_EN(ALU_EN),
    .HALTED(HALTED), .ERR_CODE(ERR_CODE), .RETIRED(RETIRED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [9:0] ev(input logic req, input logic we, input logic sel, input logic lr,
                                    input load_select_t ls, input logic inc, input logic irl,
                                    input logic alu, input logic hlt);
    return {req, we, sel, lr, ls, inc, irl, alu, hlt};
  endfunction

  function automatic logic [9:0] obs();
    return {MEM_REQ, MEM_WE, ADDR_SEL, LOAD_REG, LOAD_SELECT, INC_PC, IR_LOAD, ALU_EN, HALTED};
  endfunction

  // Architectural class of an opcode: 0 alu, 1 ld, 2 st, 3 br, 4 jmp, 5 halt, 6 illegal.
  function automatic int op_kind(input logic [4:0] op);
    if (op <= 5'd7) return 0;
    case (op)
      5'd8:  return 1;
      5'd9:  return 2;
      5'd10: return 3;
      5'd11: return 4;
      5'd12: return 5;
      default: return 6;
    endcase
  endfunction

  task automatic cyc(input string tag, input logic ack, input logic [9:0] exp);
    @(negedge CLK);
    MEM_ACK = ack;
    #1;
    check(tag, obs(), exp);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    MEM_ACK = 1'b0;
    #1;
    check("rst_outputs", obs(), ev(0,0,0,0,LOAD_PC,0,0,0,0));
    check("rst_retired", RETIRED, 0);
    check("rst_err", ERR_CODE, ERR_NONE);
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    check("rst_release_outputs", obs(), ev(0,0,0,0,LOAD_PC,0,0,0,0));
    model_ret = 0;
    model_halted = 0;
  endtask

  task automatic expect_halt(input string tag, input err_code_t err);
    cyc(tag, 1'b0, ev(0,0,0,0,LOAD_NONE,0,0,0,1));
    check({tag, "_err"}, ERR_CODE, err);
    check({tag, "_retired"}, RETIRED, model_ret);
    cyc({tag, "_stay"}, 1'b1, ev(0,0,0,0,LOAD_NONE,0,0,0,1));
    model_halted = 1;
  endtask

  task automatic fetch_phase(input int wf, output bit timed_out);
    timed_out = 0;
    for (int i = 0; i < wf && i < TO; i++) begin
      cyc("fetch_wait", 1'b0, ev(1,0,ADDR_PC,0,LOAD_NONE,0,0,0,0));
      if (i == 0) begin
        check("fetch_retired", RETIRED, model_ret);
        check("fetch_err", ERR_CODE, ERR_NONE);
      end
    end
    if (wf >= TO) begin
      expect_halt("fetch_timeout", ERR_BUS);
      timed_out = 1;
      return;
    end
    cyc("fetch_ack", 1'b1, ev(1,0,ADDR_PC,0,LOAD_NONE,0,1,0,0));
    if (wf == 0) check("fetch_retired", RETIRED, model_ret);
  endtask

  task automatic run_instr(input logic [4:0] op, input logic z, input int wf, input int wm);
    bit to;
    int k;
    logic taken;
    k = op_kind(op);
    fetch_phase(wf, to);
    if (to) return;
    cyc("inc", 1'b0, ev(0,0,0,0,LOAD_PC,1,0,0,0));
    INSTR  = {op, 14'($urandom)};
    FLAG_Z = z;
    cyc("decode", 1'b0, ev(0,0,0,0,LOAD_NONE,0,0,0,0));
    case (k)
      0: begin
        cyc("exec", 1'b0, ev(0,0,0,0,LOAD_NONE,0,0,1,0));
        cyc("wb", 1'b0, ev(0,0,0,1,LOAD_RF,0,0,0,0));
        model_ret++;
      end
      1, 2: begin
        for (int i = 0; i < wm && i < TO; i++)
          cyc("mem_wait", 1'b0, ev(1,(k == 2),ADDR_ALU,0,LOAD_NONE,0,0,0,0));
        if (wm >= TO) begin
          expect_halt("mem_timeout", ERR_BUS);
          return;
        end
        cyc("mem_ack", 1'b1, ev(1,(k == 2),ADDR_ALU,0,LOAD_NONE,0,0,0,0));
        if (k == 1) cyc("ld_wb", 1'b0, ev(0,0,0,1,LOAD_RF,0,0,0,0));
        model_ret++;
      end
      3, 4: begin
        taken = (k == 4) || z;
        if (taken) cyc("branch_taken", 1'b0, ev(0,0,0,1,LOAD_PC,0,0,0,0));
        else       cyc("branch_not_taken", 1'b0, ev(0,0,0,0,LOAD_NONE,0,0,0,0));
        model_ret++;
      end
      5: expect_halt("halt", ERR_NONE);
      default: expect_halt("illegal", ERR_ILLEGAL);
    endcase
  endtask

  task automatic mid_mem_reset();
    run_instr(5'(OP_ADD), 1'b0, 0, 0);
    cyc("mm_fetch_ack", 1'b1, ev(1,0,ADDR_PC,0,LOAD_NONE,0,1,0,0));
    check("mm_retired_before", RETIRED, model_ret);
    cyc("mm_inc", 1'b0, ev(0,0,0,0,LOAD_PC,1,0,0,0));
    INSTR = {5'(OP_LD), 14'h0123};
    cyc("mm_decode", 1'b0, ev(0,0,0,0,LOAD_NONE,0,0,0,0));
    cyc("mm_mem_wait", 1'b0, ev(1,0,ADDR_ALU,0,LOAD_NONE,0,0,0,0));
    #2;
    RESET_N = 1'b0;
    #1;
    check("mm_memreq_drop", MEM_REQ, 0);
    check("mm_rst_outputs", obs(), ev(0,0,0,0,LOAD_PC,0,0,0,0));
    check("mm_rst_retired", RETIRED, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    check("mm_release_outputs", obs(), ev(0,0,0,0,LOAD_PC,0,0,0,0));
    model_ret = 0;
    model_halted = 0;
    run_instr(5'(OP_SUB), 1'b0, 0, 0);
    run_instr(5'(OP_ST), 1'b0, 0, 0);
  endtask

  initial begin
    logic [4:0] op;
    do_reset();
    run_instr(5'(OP_ADD), 1'b0, 0, 0);
    run_instr(5'(OP_BR),  1'b1, 0, 0);
    run_instr(5'(OP_BR),  1'b0, 1, 0);
    run_instr(5'(OP_JMP), 1'b0, 0, 0);
    run_instr(5'(OP_LD),  1'b0, 2, TO - 1);
    run_instr(5'(OP_ST),  1'b1, TO - 1, 1);
    run_instr(5'h1F, 1'b0, 0, 0);
    do_reset();
    run_instr(5'(OP_HALT), 1'b0, 0, 0);
    do_reset();
    run_instr(5'(OP_ADD), 1'b0, TO, 0);
    do_reset();
    run_instr(5'(OP_ST), 1'b0, 0, TO);
    do_reset();
    mid_mem_reset();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(0, 31));
      else                           op = 5'($urandom_range(0, 11));
      run_instr(op, 1'($urandom), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
      if (model_halted) do_reset();
    end
    run_instr(5'(OP_OR), 1'b0, 0, 0);
    cyc("final_fetch", 1'b1, ev(1,0,ADDR_PC,0,LOAD_NONE,0,1,0,0));
    check("final_retired", RETIRED, model_ret);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
